vn_extrinsic_unit: RTL and testbench
====================================

# vn_extrinsic_unit

Sequential variable-node update for the LDPC min-sum decoder, the subtracting counterpart of the check-to-variable saturating accumulation. Per frame it accepts one channel LLR and DEG check-to-variable messages on a valid/ready stream. It forms their saturated total, then streams out DEG extrinsic messages, each equal to total minus that message with saturation. All values are signed two's-complement fixed point QINT.FRAC, W = INT+FRAC bits.

## Interface
- INT, 8, integer bits including sign
- FRAC, 8, fractional bits
- DEG, 3, variable-node degree (messages per frame), 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input word
- in_data  in  W  word 0 = channel LLR, words 1..DEG = check messages
- out_valid  out  1  extrinsic word valid
- out_ready  in  1  downstream accepts word
- out_data  out  W  extrinsic for message i (i = 1..DEG, arrival order)
- out_last  out  1  high with word DEG of the frame
- dec  out  1  hard decision = sign bit of total (only with VN_HARD_DEC_EN)

## Operation
- Saturation limits: MAX = 0 followed by W-1 ones (0x7FFF at W=16); MIN = 1 followed by W-1 zeros (0x8000).
- sat_add(a,b) and sat_sub(a,b): compute in W+1 bits, clamp to [MIN, MAX], truncate to W bits.
- States: ACCUM, EMIT.
- ACCUM: in_ready=1. Input handshake = in_valid & in_ready.
  - Word 0 loads acc = in_data.
  - Words k = 1..DEG: acc = sat_add(acc, in_data) and buf[k] = in_data.
  - Saturation is applied after every addition, strictly in arrival order.
  - After handshake of word DEG: total = final acc, go to EMIT, idx = 1.
- EMIT: in_ready=0, out_valid=1, out_data = sat_sub(total, buf[idx]), out_last = (idx==DEG).
  - On output handshake: idx++.
  - On handshake with out_last: go to ACCUM, word counter = 0.
- out_data, out_last, out_valid and dec are functions of registered state only; there is no combinational path from in_* to out_*.
- in_valid low during ACCUM: the block waits with no state change. out_ready low during EMIT: the block holds all outputs stable.

## Timing
- Reset (rst_n low at a clock edge):
  - state=ACCUM, counters=0, acc=0, out_valid=0, out_last=0, dec=0.
  - in_ready=0 while rst_n is low; in_ready=1 in the first cycle after release.
  - buf contents are don't-care after reset.
- Reset mid-frame or mid-emission discards the partial frame. No output word of that frame appears afterwards.
- Latency: out_valid rises in the cycle after the handshake of input word DEG.
- Minimum frame period: (DEG+1) + DEG = 2·DEG+1 cycles.
- First input word of the next frame can be accepted in the cycle after the out_last handshake.
- Input and output phases never overlap.
- dec is updated when total is registered and held until the next frame's total.

## Configuration
- VN_HARD_DEC_EN defined:
  - dec port is present; it equals total[W-1], registered with total.
  - dec is reset to 0.
- VN_HARD_DEC_EN undefined:
  - dec port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package/include vn_pkg holds:
  - W derivation, MAX/MIN constant functions of W
  - ACCUM/EMIT state encoding
  - counter width function clog2(DEG+1)
- Sub-module sat_sub: combinational W-bit saturating subtract, instantiated once on the EMIT path.
- Accumulation reuses the team's existing saturating adder.
- buf is a DEG x W register array. No RAM is used.

## Test plan
All cases use W=16 and DEG=3; values are hex Q8.8.
- Nominal: in 0100, 0080, 0040, FF00 → total 00C0; out 0040, 0080, 01C0; out_last on third word; dec=0.
- Positive saturation: in 7000, 7000, 0100, 0000 → total 7FFF; out 0FFF, 7EFF, 7FFF.
- Negative saturation in subtract: in 8000, 0200, 8000, 0000 → total 8000; out 8000 (clamped), 0000, 8000; dec=1.
- Backpressure: out_ready low 5 cycles after the first output word →
  - out_data and out_valid stay stable throughout;
  - in_ready stays 0;
  - exactly 3 words are delivered in order;
  - in_valid gaps during ACCUM yield identical results.
- Reset mid-frame: rst_n low 1 cycle after 2 input words →
  - out_valid=0 and in_ready=0 during reset;
  - a following nominal frame yields 0040, 0080, 01C0.
- Back-to-back: two frames with in_valid held high →
  - frame 2 first handshake occurs the cycle after frame 1 out_last handshake;
  - frame period is 7 cycles with out_ready=1.

Source files
------------

// File: rtl/vn_pkg.sv
// vn_pkg: shared definitions for the LDPC variable-node extrinsic unit.
// Provides the word-width derivation, the saturation limits, the
// control-state encoding, the counter-width helper and the saturating adder.
package vn_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_EMIT  = 1'b1
   } vn_state_e;

   // Word width of a QINT.FRAC value
   function automatic int vn_width(input int int_bits, input int frac_bits);
      return int_bits + frac_bits;
   endfunction

   // Width of a counter that must hold the values 0..deg
   function automatic int cnt_width(input int deg);
      return $clog2(deg + 1);
   endfunction

   // Largest positive value of a w-bit two's-complement word (0111...1)
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative value of a w-bit two's-complement word (1000...0)
   function automatic logic [63:0] sat_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

   // Saturating add of two sign-extended w-bit values, result clamped to w bits
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int                 w);
      logic signed [63:0] sum_s;
      logic signed [63:0] hi_s;
      logic signed [63:0] lo_s;
      sum_s = a + b;
      hi_s  = signed'(sat_max(w));
      lo_s  = -hi_s - 64'sd1;
      if (sum_s > hi_s) begin
         return hi_s;
      end else if (sum_s < lo_s) begin
         return lo_s;
      end else begin
         return sum_s;
      end
   endfunction

endpackage

// File: rtl/vn_extrinsic_unit_sat_sub.sv
// sat_sub: combinational W-bit two's-complement saturating subtract (y = a - b).
// The difference is formed in W+1 bits; disagreement of the two top bits
// flags overflow, and the true sign selects the clamp direction.
module sat_sub
   import vn_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   logic [W:0] diff_s;

   // Extended difference followed by clamp to [MIN, MAX]
   always_comb begin
      diff_s = {a[W-1], a} - {b[W-1], b};
      if (diff_s[W] != diff_s[W-1]) begin
         if (diff_s[W]) begin
            y = W'(sat_min(W));
         end else begin
            y = W'(sat_max(W));
         end
      end else begin
         y = diff_s[W-1:0];
      end
   end

endmodule

// File: rtl/vn_extrinsic_unit.sv
// vn_extrinsic_unit: sequential min-sum variable-node update.
// ACCUM takes the channel LLR plus DEG check messages and builds a
// saturated total in arrival order; EMIT then streams DEG extrinsics,
// total minus each stored message, saturated. Input and output phases
// never overlap. Optional macro VN_HARD_DEC_EN adds the registered
// hard-decision output dec (sign of the total).
module vn_extrinsic_unit
   import vn_pkg::*;
#(
   parameter int INT  = 8,
   parameter int FRAC = 8,
   parameter int DEG  = 3
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [vn_width(INT, FRAC)-1:0]     in_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [vn_width(INT, FRAC)-1:0]     out_data,
   output logic                               out_last
`ifdef VN_HARD_DEC_EN
   ,
   output logic                               dec
`endif
);

   localparam int W  = vn_width(INT, FRAC);
   localparam int CW = cnt_width(DEG);
   localparam int IW = cnt_width(DEG - 1);

   vn_state_e       state_r;
   vn_state_e       state_s;
   logic [CW-1:0]   cnt_r;
   logic [IW-1:0]   idx_r;
   logic [W-1:0]    acc_r;
   logic [W-1:0]    buf_r [0:DEG-1];
   logic            in_ready_r;
   logic            out_valid_r;
   logic            out_last_r;
   logic            in_hs_s;
   logic            out_hs_s;
   logic            last_in_s;
   logic [W-1:0]    sum_s;
   logic [W-1:0]    ext_s;

   // Handshakes, running saturated sum and next-state selection
   always_comb begin
      in_hs_s   = in_valid & in_ready_r;
      out_hs_s  = out_valid_r & out_ready;
      last_in_s = in_hs_s && (cnt_r == CW'(DEG));
      sum_s     = W'(sat_add(64'(signed'(acc_r)), 64'(signed'(in_data)), W));
      state_s   = state_r;
      case (state_r)
         ST_ACCUM: begin
            if (last_in_s) begin
               state_s = ST_EMIT;
            end else begin
               state_s = ST_ACCUM;
            end
         end
         ST_EMIT: begin
            if (out_hs_s && out_last_r) begin
               state_s = ST_ACCUM;
            end else begin
               state_s = ST_EMIT;
            end
         end
         default: state_s = ST_ACCUM;
      endcase
   end

   // State, counters, accumulator and registered handshake flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_ACCUM;
         cnt_r       <= CW'(0);
         idx_r       <= IW'(0);
         acc_r       <= W'(0);
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == ST_ACCUM);
         out_valid_r <= (state_s == ST_EMIT);
         case (state_r)
            ST_ACCUM: begin
               if (in_hs_s) begin
                  if (cnt_r == CW'(0)) begin
                     acc_r <= in_data;
                  end else begin
                     acc_r <= sum_s;
                  end
                  if (cnt_r == CW'(DEG)) begin
                     cnt_r      <= CW'(0);
                     idx_r      <= IW'(0);
                     out_last_r <= 1'b0;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out_hs_s) begin
                  if (out_last_r) begin
                     idx_r      <= IW'(0);
                     out_last_r <= 1'b0;
                  end else begin
                     idx_r      <= idx_r + IW'(1);
                     out_last_r <= (idx_r == IW'(DEG - 2));
                  end
               end
            end
            default: begin
               cnt_r      <= CW'(0);
               idx_r      <= IW'(0);
               out_last_r <= 1'b0;
            end
         endcase
      end
   end

   // Message store; contents are don't-care after reset so no reset branch
   always_ff @(posedge clk) begin
      if ((state_r == ST_ACCUM) && in_hs_s && (cnt_r != CW'(0))) begin
         buf_r[IW'(cnt_r - CW'(1))] <= in_data;
      end
   end

   sat_sub #(.W(W)) u_sat_sub (
      .a (acc_r),
      .b (buf_r[idx_r]),
      .y (ext_s)
   );

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_data  = ext_s;

`ifdef VN_HARD_DEC_EN
   logic dec_r;

   // Hard decision captured together with the frame total
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_r <= 1'b0;
      end else if ((state_r == ST_ACCUM) && last_in_s) begin
         dec_r <= sum_s[W-1];
      end else begin
         dec_r <= dec_r;
      end
   end

   assign dec = dec_r;
`endif

endmodule

// File: tb/tb_vn_extrinsic_unit.sv
// Directed self-checking bench for vn_extrinsic_unit (W=16, DEG=3, Q8.8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vn_extrinsic_unit;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_data   = 16'h0000;
   logic        in_ready;
   logic        out_valid;
   logic        out_last;
   logic [15:0] out_data;
`ifdef VN_HARD_DEC_EN
   logic        dec;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hs_q[$];
   int last_q[$];
   int base_hs;
   int base_last;

   vn_extrinsic_unit #(.INT(8), .FRAC(8), .DEG(3)) dut (
`ifdef VN_HARD_DEC_EN
      .dec       (dec),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (out_valid && out_ready && out_last) last_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one word and wait (bounded) until it has been accepted; in_valid stays high
   task automatic push(input logic [15:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", in_ready, 1);
      @(negedge clk);
   endtask

   task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
      push(a);
      push(b);
      push(c);
      push(d);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for an output word, check it, complete its handshake
   task automatic pop(input logic [15:0] d, input logic l);
      int n = 0;
      out_ready = 1'b1;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pop_valid", out_valid, 1);
      chk("pop_data", out_data, d);
      chk("pop_last", out_last, l);
      @(negedge clk);
   endtask

   task automatic pop_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      pop(a, 1'b0);
      pop(b, 1'b0);
      pop(c, 1'b1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
`ifdef VN_HARD_DEC_EN
      chk("rst_dec", dec, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);

      // Nominal frame
      push_frame(16'h0100, 16'h0080, 16'h0040, 16'hFF00);
      chk("nom_latency_valid", out_valid, 1);
      chk("nom_emit_in_ready", in_ready, 0);
`ifdef VN_HARD_DEC_EN
      chk("nom_dec", dec, 0);
`endif
      pop_frame(16'h0040, 16'h0080, 16'h01C0);
      chk("nom_idle_valid", out_valid, 0);
      chk("nom_idle_in_ready", in_ready, 1);

      // Positive saturation
      push_frame(16'h7000, 16'h7000, 16'h0100, 16'h0000);
`ifdef VN_HARD_DEC_EN
      chk("pos_dec", dec, 0);
`endif
      pop_frame(16'h0FFF, 16'h7EFF, 16'h7FFF);

      // Negative saturation in the subtract
      push_frame(16'h8000, 16'h0200, 16'h8000, 16'h0000);
`ifdef VN_HARD_DEC_EN
      chk("neg_dec", dec, 1);
`endif
      pop_frame(16'h8000, 16'h0000, 16'h8000);

      // Input gaps during ACCUM, then output backpressure
      push(16'h0100);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      push(16'h0080);
      in_valid = 1'b0;
      @(negedge clk);
      push(16'h0040);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      push(16'hFF00);
      in_valid = 1'b0;
      pop(16'h0040, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, 16'h0080);
         chk("bp_last", out_last, 0);
         chk("bp_in_ready", in_ready, 0);
         @(negedge clk);
      end
      base_last = last_q.size();
      pop(16'h0080, 1'b0);
      pop(16'h01C0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("bp_no_extra_word", out_valid, 0);
         @(negedge clk);
      end
      chk("bp_one_last", last_q.size() - base_last, 1);

      // Reset in the middle of a frame
      push(16'h0100);
      push(16'h0080);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_in_ready", in_ready, 1);
      chk("mid_rel_out_valid", out_valid, 0);
      push_frame(16'h0100, 16'h0080, 16'h0040, 16'hFF00);
      pop_frame(16'h0040, 16'h0080, 16'h01C0);

      // Back-to-back frames with in_valid held high
      base_hs   = hs_q.size();
      base_last = last_q.size();
      push(16'h0100);
      push(16'h0080);
      push(16'h0040);
      push(16'hFF00);
      in_data = 16'h7000;
      pop_frame(16'h0040, 16'h0080, 16'h01C0);
      push(16'h7000);
      push(16'h7000);
      push(16'h0100);
      push(16'h0000);
      in_valid = 1'b0;
      pop_frame(16'h0FFF, 16'h7EFF, 16'h7FFF);
      chk("b2b_hs_count", hs_q.size() - base_hs, 8);
      chk("b2b_period", hs_q[base_hs + 4] - hs_q[base_hs], 7);
      chk("b2b_restart", hs_q[base_hs + 4] - last_q[base_last], 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
